bitlet_operand_packer: RTL and testbench
========================================

# bitlet_operand_packer

Transmit-side front end for the Bitlet calculator. It accepts a stream of signed (weight, activation) pairs, one pair per handshake. For each pair it folds the weight sign into the activation and packs the result into the N_total-lane `Wabs_vec`/`Afix_vec` vectors. It issues each vector with a single-cycle `Wabs_vld` pulse and ends every dot product with a single-cycle `flush`, so its outputs connect port-for-port to the calculator inputs of the same names.

## Interface
- N_total, 64: lane count; must match the downstream calculator.
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_vld  in  1  input pair valid.
- in_rdy  out  1  block can accept a pair; high only in FILL.
- in_w  in  `Wid_abs+1  weight, two's complement.
- in_a  in  `Wid_fix  activation, two's complement.
- in_last  in  1  pair is the last of the current dot product.
- cfg_prune  in  `Max_quant  prune setting; sampled on the first accepted beat of each dot product.
- cfg_gap  in  8  idle cycles inserted after each issued vector; sampled when the vector is issued.
- N_calculate  out  $clog2(N_total)  number of valid lanes minus 1; valid with `Wabs_vld`.
- prune  out  `Max_quant  latched cfg_prune; held for the whole dot product.
- flush  out  1  end-of-dot-product pulse.
- Wabs_vld  out  1  vector-issue pulse.
- Wabs_vec  out  N_total*`Wid_abs  weight magnitudes; lane i occupies bits [i*`Wid_abs +: `Wid_abs].
- Afix_vec  out  N_total*`Wid_fix  sign-folded activations; lane i occupies bits [i*`Wid_fix +: `Wid_fix].

## Operation
- Sign fold, per beat:
  - Wabs = |in_w|. If in_w = −2^`Wid_abs, Wabs saturates to all ones.
  - Afix = in_a when in_w ≥ 0; otherwise −in_a. If in_a = −2^(`Wid_fix−1) and in_w < 0, Afix saturates to 2^(`Wid_fix−1)−1.
  - A zero weight gives Wabs = 0 and Afix = in_a.
- Lane fill:
  - Lane pointer starts at 0 and writes the current lane on each accepted beat (in_vld & in_rdy), then increments.
  - Unwritten lanes hold Wabs = 0 and Afix = 0.
- State machine. States: FILL, ISSUE, FLUSH, WAIT.
  - FILL → ISSUE on an accepted beat that either fills lane N_total−1 or carries in_last.
  - ISSUE → FLUSH if the issued vector contains the in_last beat.
  - ISSUE → WAIT if cfg_gap ≠ 0.
  - ISSUE → FILL otherwise.
  - FLUSH → WAIT if the latched gap ≠ 0, else → FILL.
  - WAIT: the gap counter decrements each cycle; → FILL when the counter reaches 1.
- ISSUE cycle:
  - Wabs_vld = 1, vectors valid, N_calculate = lane pointer − 1.
  - At the end of this cycle the lane buffer and lane pointer clear.
- prune:
  - Updates only on the first beat of a dot product, i.e. the first beat after reset or after a FLUSH.
  - Stays constant through that dot product's vectors and its flush.
- Boundary cases:
  - Full and last on the same beat: one ISSUE, then FLUSH. No empty vector is issued.
  - A single-beat dot product: ISSUE with N_calculate = 0, then FLUSH.
  - A multi-vector dot product: flush follows only the final vector.
  - in_vld while in_rdy = 0: the pair is held upstream; it is not a loss.
  - Reset mid-operation: the partial vector is discarded and no flush is emitted.

## Timing
- Reset values:
  - State FILL, so in_rdy = 1 once rst_n releases.
  - Wabs_vld = 0, flush = 0, N_calculate = 0, prune = 0.
  - Wabs_vec = 0, Afix_vec = 0, lane pointer = 0.
- All outputs except in_rdy are registered. in_rdy is decoded from the state register.
- Closing beat accepted in cycle t:
  - t+1: Wabs_vld = 1.
  - t+2: flush = 1 if the vector was last.
  - FILL (in_rdy = 1) resumes at t+2, +1 if a flush was issued, + cfg_gap.
- Wabs_vld and flush are never high in the same cycle. Each is exactly one cycle wide.
- Vector and N_calculate outputs read zero outside ISSUE.

## Test plan
- N_total = 4, cfg_gap = 0. Stream 4 pairs (w, a) = (3,5), (−2,7), (0,−1), (1,1) with in_last on the 4th beat.
  - Expect one Wabs_vld with Wabs lanes {3,2,0,1}, Afix lanes {5,−7,−1,1}, N_calculate = 3.
  - Expect flush on the next cycle.
- N_total = 4. Stream 6 pairs with in_last on the 6th.
  - First vector: N_calculate = 3, no flush after it.
  - Second vector: N_calculate = 1, lanes 2–3 zero, then flush.
- Saturation: in_w = −2^`Wid_abs with in_a = −2^(`Wid_fix−1), single beat with in_last.
  - Expect Wabs all ones, Afix = 2^(`Wid_fix−1)−1, N_calculate = 0.
- cfg_gap = 3, two back-to-back full vectors with in_vld held high.
  - Expect exactly 3 cycles with in_rdy low after each ISSUE cycle, in addition to the ISSUE cycle itself.
- Change cfg_prune from 2 to 5 mid dot product.
  - Expect prune = 2 until after flush, and prune = 5 from the first beat of the next dot product.
- Assert rst_n low after 2 of 4 beats, then release and send a fresh 4-beat product.
  - Expect no Wabs_vld and no flush for the aborted data.
  - The fresh vector must contain only the new pairs.

Source files
------------

// File: rtl/bitlet_operand_packer_if.sv
// rtl/bitlet_operand_packer_if.sv - pair-stream input and calculator-side vector bus for the operand packer
//
// Purpose: bundles the upstream (weight, activation) handshake, the per-product
// configuration and the calculator-facing vector outputs.
// Ports (master = upstream source / calculator side, slave = packer):
//   in_vld, in_w, in_a, in_last  pair stream into the packer
//   in_rdy                       packer can accept a pair
//   cfg_prune, cfg_gap           prune setting and post-issue idle gap
//   N_calculate, prune, flush,
//   Wabs_vld, Wabs_vec, Afix_vec calculator inputs driven by the packer
interface bitlet_operand_packer_if #(
    parameter int N_TOTAL   = 64,
    parameter int WID_ABS   = 8,
    parameter int WID_FIX   = 16,
    parameter int MAX_QUANT = 4
);
    logic                          in_vld;
    logic                          in_rdy;
    logic [WID_ABS:0]              in_w;
    logic [WID_FIX-1:0]            in_a;
    logic                          in_last;
    logic [MAX_QUANT-1:0]          cfg_prune;
    logic [7:0]                    cfg_gap;
    logic [$clog2(N_TOTAL)-1:0]    N_calculate;
    logic [MAX_QUANT-1:0]          prune;
    logic                          flush;
    logic                          Wabs_vld;
    logic [N_TOTAL*WID_ABS-1:0]    Wabs_vec;
    logic [N_TOTAL*WID_FIX-1:0]    Afix_vec;

    modport master (
        output in_vld, in_w, in_a, in_last, cfg_prune, cfg_gap,
        input  in_rdy, N_calculate, prune, flush, Wabs_vld, Wabs_vec, Afix_vec
    );

    modport slave (
        input  in_vld, in_w, in_a, in_last, cfg_prune, cfg_gap,
        output in_rdy, N_calculate, prune, flush, Wabs_vld, Wabs_vec, Afix_vec
    );
endinterface

// File: rtl/bitlet_operand_packer.sv
// rtl/bitlet_operand_packer.sv - sign-folding lane packer feeding the Bitlet calculator
//
// Purpose: accepts signed (weight, activation) pairs, folds the weight sign into
// the activation, packs N_TOTAL lanes per vector, issues each vector with a
// one-cycle Wabs_vld pulse and closes each dot product with a one-cycle flush.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of bitlet_operand_packer_if (pair stream in, vectors out)
module bitlet_operand_packer #(
    parameter int N_TOTAL   = 64,
    parameter int WID_ABS   = 8,
    parameter int WID_FIX   = 16,
    parameter int MAX_QUANT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bitlet_operand_packer_if.slave    bus
);
    localparam int PW = $clog2(N_TOTAL);

    typedef enum logic [1:0] {FILL, ISSUE, FLUSH, WAIT} state_t;

    state_t                     state_q, state_d;
    logic [WID_ABS-1:0]         wbuf_q [N_TOTAL];
    logic [WID_ABS-1:0]         wbuf_d [N_TOTAL];
    logic [WID_FIX-1:0]         abuf_q [N_TOTAL];
    logic [WID_FIX-1:0]         abuf_d [N_TOTAL];
    logic [PW-1:0]              ptr_q, ptr_d;
    logic                       last_q, last_d;
    logic [7:0]                 gap_q, gap_d;
    logic                       first_q, first_d;
    logic [MAX_QUANT-1:0]       prune_q, prune_d;
    logic                       vld_q, vld_d;
    logic                       flush_q, flush_d;
    logic [PW-1:0]              ncalc_q, ncalc_d;
    logic [N_TOTAL*WID_ABS-1:0] wvec_q, wvec_d;
    logic [N_TOTAL*WID_FIX-1:0] avec_q, avec_d;

    // Sign fold of the incoming beat
    logic                 w_neg;
    logic [WID_ABS:0]     w_mag;
    logic [WID_ABS-1:0]   wabs;
    logic                 a_is_min;
    logic [WID_FIX-1:0]   afix;
    logic                 accept;
    logic                 close;

    assign w_neg = bus.in_w[WID_ABS];
    assign w_mag = w_neg ? (~bus.in_w + 1'b1) : bus.in_w;
    // Only -2^WID_ABS leaves the top bit set after negation; clamp it.
    assign wabs  = w_mag[WID_ABS] ? {WID_ABS{1'b1}} : w_mag[WID_ABS-1:0];

    assign a_is_min = (bus.in_a == {1'b1, {(WID_FIX-1){1'b0}}});
    assign afix     = !w_neg   ? bus.in_a :
                      a_is_min ? {1'b0, {(WID_FIX-1){1'b1}}} :
                                 (~bus.in_a + 1'b1);

    assign accept = bus.in_vld && (state_q == FILL);
    assign close  = accept && ((ptr_q == PW'(N_TOTAL-1)) || bus.in_last);

    always_comb begin
        state_d = state_q;
        wbuf_d  = wbuf_q;
        abuf_d  = abuf_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        gap_d   = gap_q;
        first_d = first_q;
        prune_d = prune_q;
        vld_d   = 1'b0;
        flush_d = 1'b0;
        ncalc_d = '0;
        wvec_d  = '0;
        avec_d  = '0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    wbuf_d[ptr_q] = wabs;
                    abuf_d[ptr_q] = afix;
                    ptr_d         = ptr_q + PW'(1);
                    if (first_q) begin
                        prune_d = bus.cfg_prune;
                        first_d = 1'b0;
                    end
                end
                if (close) begin
                    state_d = ISSUE;
                    last_d  = bus.in_last;
                    vld_d   = 1'b1;
                    // Pointer before increment equals valid lanes minus one.
                    ncalc_d = ptr_q;
                    for (int i = 0; i < N_TOTAL; i++) begin
                        wvec_d[i*WID_ABS +: WID_ABS] = wbuf_d[i];
                        avec_d[i*WID_FIX +: WID_FIX] = abuf_d[i];
                    end
                end
            end
            ISSUE: begin
                for (int i = 0; i < N_TOTAL; i++) begin
                    wbuf_d[i] = '0;
                    abuf_d[i] = '0;
                end
                ptr_d = '0;
                gap_d = bus.cfg_gap;
                if (last_q) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end else if (bus.cfg_gap != 8'd0) begin
                    state_d = WAIT;
                end else begin
                    state_d = FILL;
                end
            end
            FLUSH: begin
                // Next accepted beat opens a new dot product and relatches prune.
                first_d = 1'b1;
                state_d = (gap_q != 8'd0) ? WAIT : FILL;
            end
            WAIT: begin
                if (gap_q <= 8'd1) begin
                    state_d = FILL;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            for (int i = 0; i < N_TOTAL; i++) begin
                wbuf_q[i] <= '0;
                abuf_q[i] <= '0;
            end
            ptr_q   <= '0;
            last_q  <= 1'b0;
            gap_q   <= '0;
            first_q <= 1'b1;
            prune_q <= '0;
            vld_q   <= 1'b0;
            flush_q <= 1'b0;
            ncalc_q <= '0;
            wvec_q  <= '0;
            avec_q  <= '0;
        end else begin
            state_q <= state_d;
            wbuf_q  <= wbuf_d;
            abuf_q  <= abuf_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            first_q <= first_d;
            prune_q <= prune_d;
            vld_q   <= vld_d;
            flush_q <= flush_d;
            ncalc_q <= ncalc_d;
            wvec_q  <= wvec_d;
            avec_q  <= avec_d;
        end
    end

    assign bus.in_rdy      = (state_q == FILL);
    assign bus.Wabs_vld    = vld_q;
    assign bus.flush       = flush_q;
    assign bus.N_calculate = ncalc_q;
    assign bus.prune       = prune_q;
    assign bus.Wabs_vec    = wvec_q;
    assign bus.Afix_vec    = avec_q;
endmodule

// File: tb/tb_bitlet_operand_packer.sv
// tb/tb_bitlet_operand_packer.sv - self-checking bench for bitlet_operand_packer
module tb_bitlet_operand_packer;
    localparam int N  = 4;
    localparam int WA = 8;
    localparam int WF = 16;
    localparam int MQ = 4;
    localparam int BUDGET = 400;

    logic clk;
    logic rst_n;

    bitlet_operand_packer_if #(.N_TOTAL(N), .WID_ABS(WA), .WID_FIX(WF), .MAX_QUANT(MQ)) bus ();

    bitlet_operand_packer #(.N_TOTAL(N), .WID_ABS(WA), .WID_FIX(WF), .MAX_QUANT(MQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              is_flush;
        logic [N*WA-1:0] w;
        logic [N*WF-1:0] a;
        int              nc;
        int              pr;
    } ev_t;

    ev_t exp_q[$];
    int  run_q[$];
    int  pw[32];
    int  pa[32];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Sign fold from the arithmetic definition: magnitude and negation, clamped to range.
    task automatic fold(input int w, input int a, output int wa, output int af);
        if (w < 0) begin
            wa = (-w > (1 << WA) - 1) ? (1 << WA) - 1 : -w;
            af = (-a > (1 << (WF-1)) - 1) ? (1 << (WF-1)) - 1 : -a;
        end else begin
            wa = w;
            af = a;
        end
    endtask

    task automatic build_model(input int n, input int gap, input int pr);
        int  base;
        int  cnt;
        int  wa;
        int  af;
        bit  last;
        ev_t e;
        base = 0;
        while (base < n) begin
            cnt = (n - base > N) ? N : n - base;
            e.is_flush = 0; e.w = '0; e.a = '0; e.nc = cnt - 1; e.pr = pr;
            for (int i = 0; i < cnt; i++) begin
                fold(pw[base+i], pa[base+i], wa, af);
                e.w[i*WA +: WA] = wa[WA-1:0];
                e.a[i*WF +: WF] = af[WF-1:0];
            end
            base += cnt;
            last = (base >= n);
            exp_q.push_back(e);
            run_q.push_back(1 + (last ? 1 : 0) + gap);
            if (last) begin
                e.is_flush = 1; e.w = '0; e.a = '0; e.nc = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            pw[i] = int'($urandom_range(0, (1 << (WA+1)) - 1)) - (1 << WA);
            pa[i] = int'($urandom_range(0, (1 << WF) - 1)) - (1 << (WF-1));
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_rdy"}, bus.in_rdy, 1);
        chk({tag, "_wabs_vld"}, bus.Wabs_vld, 0);
        chk({tag, "_flush"}, bus.flush, 0);
        chk({tag, "_prune"}, bus.prune, 0);
        chk({tag, "_ncalc"}, bus.N_calculate, 0);
        chk({tag, "_wabs_vec"}, bus.Wabs_vec, 0);
        chk({tag, "_afix_vec"}, bus.Afix_vec, 0);
    endtask

    task automatic run_product(input int n, input int gap, input int pr0, input int pr_mid, input bit rand_vld);
        int  idx;
        int  cyc;
        int  low;
        int  last_vec;
        ev_t e;
        idx = 0; cyc = 0; low = 0; last_vec = -100;
        build_model(n, gap, pr0);
        bus.cfg_gap   = gap[7:0];
        bus.cfg_prune = pr0[MQ-1:0];
        while ((idx < n || exp_q.size() > 0 || run_q.size() > 0) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (bus.Wabs_vld) begin
                chk("vld_flush_overlap", bus.flush, 0);
                if (exp_q.size() > 0 && !exp_q[0].is_flush) begin
                    e = exp_q.pop_front();
                    chk("wabs_vec", bus.Wabs_vec, e.w);
                    chk("afix_vec", bus.Afix_vec, e.a);
                    chk("n_calculate", bus.N_calculate, e.nc);
                    chk("vec_prune", bus.prune, e.pr);
                    last_vec = cyc;
                end else begin
                    chk("unexpected_vec", bus.Wabs_vld, 0);
                end
            end else begin
                chk("idle_wabs_vec", bus.Wabs_vec, 0);
                chk("idle_afix_vec", bus.Afix_vec, 0);
                chk("idle_ncalc", bus.N_calculate, 0);
            end
            if (bus.flush) begin
                if (exp_q.size() > 0 && exp_q[0].is_flush) begin
                    e = exp_q.pop_front();
                    chk("flush_latency", cyc, last_vec + 1);
                    chk("flush_prune", bus.prune, e.pr);
                end else begin
                    chk("unexpected_flush", bus.flush, 0);
                end
            end
            if (!bus.in_rdy) begin
                low++;
            end else if (low > 0) begin
                if (run_q.size() > 0) chk("rdy_low_run", low, run_q.pop_front());
                else chk("unexpected_stall", low, 0);
                low = 0;
            end
            if (idx >= 1) bus.cfg_prune = pr_mid[MQ-1:0];
            if (idx < n) begin
                bus.in_vld  = rand_vld ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.in_w    = pw[idx][WA:0];
                bus.in_a    = pa[idx][WF-1:0];
                bus.in_last = (idx == n - 1);
                if (bus.in_vld && bus.in_rdy) idx++;
            end else begin
                bus.in_vld  = 1'b0;
                bus.in_last = 1'b0;
            end
        end
        chk("product_done", exp_q.size() + run_q.size() + (n - idx), 0);
        exp_q.delete();
        run_q.delete();
    endtask

    initial begin
        int k;
        int cyc;
        clk = 0;
        rst_n = 0;
        bus.in_vld = 0; bus.in_w = '0; bus.in_a = '0; bus.in_last = 0;
        bus.cfg_prune = '0; bus.cfg_gap = '0;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1;
        @(negedge clk);
        check_reset_state("post_reset");

        // Directed example vector
        pw[0] = 3;  pa[0] = 5;
        pw[1] = -2; pa[1] = 7;
        pw[2] = 0;  pa[2] = -1;
        pw[3] = 1;  pa[3] = 1;
        run_product(4, 0, 0, 0, 0);

        // Two vectors in one product
        fill_rand(6);
        run_product(6, 0, 1, 1, 0);

        // Saturating beat, single-beat product
        pw[0] = -(1 << WA); pa[0] = -(1 << (WF-1));
        run_product(1, 0, 0, 0, 0);

        // Gap of 3 with in_vld held high across two full vectors
        fill_rand(8);
        run_product(8, 3, 0, 0, 0);

        // Prune change mid product, then a product with the new setting
        fill_rand(6);
        run_product(6, 0, 2, 5, 0);
        fill_rand(4);
        run_product(4, 0, 5, 5, 0);

        // Reset after 2 of 4 beats
        fill_rand(4);
        bus.cfg_prune = 4'd3;
        bus.cfg_gap   = 8'd0;
        k = 0; cyc = 0;
        while (k < 2 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            bus.in_vld  = 1'b1;
            bus.in_w    = pw[k][WA:0];
            bus.in_a    = pa[k][WF-1:0];
            bus.in_last = 1'b0;
            if (bus.in_rdy) k++;
        end
        chk("abort_beats_sent", k, 2);
        @(negedge clk);
        chk("abort_no_vld", bus.Wabs_vld, 0);
        bus.in_vld = 1'b0;
        rst_n = 0;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_vld_after", bus.Wabs_vld, 0);
            chk("abort_no_flush_after", bus.flush, 0);
        end
        fill_rand(4);
        run_product(4, 0, 6, 6, 0);

        // Randomized products
        for (int r = 0; r < 8; r++) begin
            int n;
            int g;
            int p;
            n = int'($urandom_range(1, 10));
            g = int'($urandom_range(0, 2));
            p = int'($urandom_range(0, (1 << MQ) - 1));
            fill_rand(n);
            run_product(n, g, p, int'($urandom_range(0, (1 << MQ) - 1)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
